// File: rtl/map_probe_arbiter.sv
// map_probe_arbiter: time-shares one combinational mapRom port among N_REQ movers.
// A granted mover gets its 12 wall probes sequenced one per cycle around its
// latched centre, then a {L,U,R,D} free-direction mask plus a one-cycle done.
// Optional build macro MAP_PROBE_PRIO_EN: requester 0 has fixed priority over
// the round-robin among the others.
module map_probe_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned COORD_W = 9,
  localparam int unsigned ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*COORD_W-1:0]   req_x,
  input  logic [N_REQ*COORD_W-1:0]   req_y,
  output logic [COORD_W-1:0]         rom_x,
  output logic [COORD_W-1:0]         rom_y,
  input  logic [1:0]                 rom_pixel,
  output logic                       busy,
  output logic [ID_W-1:0]            grant_id,
  output logic [N_REQ-1:0]           done,
  output logic [3:0]                 flags
);

  typedef enum logic [1:0] {StIdle, StProbe, StDone} state_e;

  state_e               state_q;
  logic [ID_W-1:0]      ptr_q;
  logic [COORD_W-1:0]   cx_q, cy_q;
  logic [COORD_W-1:0]   last_x_q, last_y_q;
  logic [3:0]           k_q;
  logic [3:0]           acc_q;

  logic signed [5:0]    dx, dy;
  logic [1:0]           dir;
  logic [COORD_W-1:0]   probe_x, probe_y;
  logic                 pick_found;
  logic [ID_W-1:0]      pick_id;
  int unsigned          idx;
  logic [ID_W-1:0]      ridx;

  // Probe offset table: three probes per direction, L, U, R, D; dir is the acc bit.
  always_comb begin
    dx  = '0;
    dy  = '0;
    dir = 2'd0;
    case (k_q)
      4'd0:  begin dx = -6'sd13; dy =  6'sd0;  dir = 2'd3; end
      4'd1:  begin dx = -6'sd11; dy = -6'sd13; dir = 2'd3; end
      4'd2:  begin dx = -6'sd11; dy =  6'sd12; dir = 2'd3; end
      4'd3:  begin dx =  6'sd0;  dy = -6'sd13; dir = 2'd2; end
      4'd4:  begin dx = -6'sd13; dy = -6'sd11; dir = 2'd2; end
      4'd5:  begin dx =  6'sd12; dy = -6'sd11; dir = 2'd2; end
      4'd6:  begin dx =  6'sd12; dy =  6'sd0;  dir = 2'd1; end
      4'd7:  begin dx =  6'sd11; dy = -6'sd13; dir = 2'd1; end
      4'd8:  begin dx =  6'sd11; dy =  6'sd12; dir = 2'd1; end
      4'd9:  begin dx =  6'sd0;  dy =  6'sd12; dir = 2'd0; end
      4'd10: begin dx = -6'sd13; dy =  6'sd11; dir = 2'd0; end
      4'd11: begin dx =  6'sd12; dy =  6'sd11; dir = 2'd0; end
      default: ;
    endcase
  end

  // Sign-extended add wraps modulo 2^COORD_W; no clamping at map edges.
  assign probe_x = cx_q + {{(COORD_W-6){dx[5]}}, dx};
  assign probe_y = cy_q + {{(COORD_W-6){dy[5]}}, dy};

  // ROM address follows the live probe while probing, otherwise holds the last one.
  assign rom_x = (state_q == StProbe) ? probe_x : last_x_q;
  assign rom_y = (state_q == StProbe) ? probe_y : last_y_q;

  // Round-robin pick starting at the pointer; optional fixed priority for requester 0.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    ridx       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx  = (32'(ptr_q) + i) % N_REQ;
      ridx = ID_W'(idx);
      if (!pick_found && req[ridx]) begin
        pick_found = 1'b1;
        pick_id    = ridx;
      end
    end
`ifdef MAP_PROBE_PRIO_EN
    if (req[0]) begin
      pick_found = 1'b1;
      pick_id    = '0;
    end
`endif
  end

  // Arbitration / probe sequencing FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      last_x_q <= '0;
      last_y_q <= '0;
      k_q      <= '0;
      acc_q    <= 4'b1111;
      busy     <= 1'b0;
      grant_id <= '0;
      done     <= '0;
      flags    <= 4'b0000;
    end else begin
      done <= '0;
      case (state_q)
        StIdle: begin
          if (pick_found) begin
            cx_q     <= req_x[pick_id*COORD_W +: COORD_W];
            cy_q     <= req_y[pick_id*COORD_W +: COORD_W];
            grant_id <= pick_id;
            busy     <= 1'b1;
            k_q      <= '0;
            acc_q    <= 4'b1111;
            state_q  <= StProbe;
          end
        end
        StProbe: begin
          last_x_q <= probe_x;
          last_y_q <= probe_y;
          if (rom_pixel == 2'b00) acc_q[dir] <= 1'b0;
          if (k_q == 4'd11) begin
            state_q <= StDone;
          end else begin
            k_q <= k_q + 4'd1;
          end
        end
        StDone: begin
          flags          <= acc_q;
          done[grant_id] <= 1'b1;
          busy           <= 1'b0;
`ifdef MAP_PROBE_PRIO_EN
          // A priority grant to requester 0 leaves the rotation among the rest untouched.
          if (grant_id != '0) begin
            ptr_q <= (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + 1'b1;
          end
`else
          ptr_q <= (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + 1'b1;
`endif
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/map_probe_arbiter.md
Name: map_probe_arbiter

Overview:
- Time-shares one mapRom query port among several movers (pacman plus monsters). Today each mover instantiates ten private ROM copies for wall probing.
- For a granted requester, sequences the 12 wall probes around its (x,y) centre, one per cycle, and returns a 4-bit free-direction mask in the L/U/R/D one-hot-per-bit format (L=bit3, U=bit2, R=bit1, D=bit0).
- Sits between the pacman/monster movement logic and a single combinational mapRom instance.

Parameters:
- N_REQ, 4, number of requesters; index 0 is pacman.
- COORD_W, 9, map coordinate width in bits.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req  input  N_REQ  level request per requester; held until its done pulse.
- req_x  input  N_REQ*COORD_W  flattened centre x; requester i occupies bits [i*COORD_W +: COORD_W].
- req_y  input  N_REQ*COORD_W  flattened centre y, same packing.
- rom_x  output  COORD_W  probe x to mapRom.
- rom_y  output  COORD_W  probe y to mapRom.
- rom_pixel  input  2  mapRom pixel for (rom_x,rom_y), combinational, same cycle; 2'b00 = wall.
- busy  output  1  high while a probe sequence is in progress.
- grant_id  output  2  index of the requester currently being served.
- done  output  N_REQ  one-cycle pulse to the served requester when flags are valid.
- flags  output  4  free-direction mask {L,U,R,D}; holds until the next done.

Behaviour:
- Reset values: busy=0, done=0, flags=4'b0000, grant_id=0, rom_x=0, rom_y=0, round-robin pointer=0, state IDLE.
- States: IDLE -> PROBE -> DONE -> IDLE.
- IDLE:
  - Round-robin pick among asserted req, starting at pointer.
  - On pick: latch that requester's x,y into cx,cy; set grant_id; busy=1; probe index k=0; accumulator acc=4'b1111; go to PROBE.
  - If no req is asserted, stay in IDLE.
- PROBE, one probe per cycle for k=0..11, fixed order:
  - L: (cx-13,cy), (cx-11,cy-13), (cx-11,cy+12)
  - U: (cx,cy-13), (cx-13,cy-11), (cx+12,cy-11)
  - R: (cx+12,cy), (cx+11,cy-13), (cx+11,cy+12)
  - D: (cx,cy+12), (cx-13,cy+11), (cx+12,cy+11)
- Each cycle in PROBE:
  - rom_x/rom_y drive probe k combinationally from cx,cy,k.
  - rom_pixel is sampled at the clock edge.
  - If rom_pixel==2'b00, clear the acc bit for that direction.
  - After k=11, go to DONE.
- Coordinate arithmetic is modulo 2^COORD_W; underflow wraps (cx=5, offset -13 gives 504). No clamping.
- DONE (one cycle):
  - flags<=acc; done[grant_id]<=1; busy<=0.
  - pointer<=grant_id+1, wrapping to 0 at N_REQ.
  - Return to IDLE.
- Latency: from the IDLE cycle that sees req, grant takes 1 cycle, then 12 probe cycles, then done 1 cycle later. Total 14 cycles; a new grant is possible on the cycle after done.
- Single requester held high gets served back-to-back every 14 cycles.
- req or req_x/req_y changing mid-sequence: ignored. Coordinates were latched at grant; the sequence completes and done still pulses.
- Requester whose req drops before grant is skipped.
- reset asserted mid-sequence: returns to IDLE with reset values next edge; no done pulse.
- rom_x/rom_y outside PROBE: hold last value; the don't-care ROM output is not sampled.
- flags is meaningful only together with done[i]; requesters capture it on their done pulse.

Optional Feature:
- Macro: MAP_PROBE_PRIO_EN.
- Defined: requester 0 (pacman) has fixed priority; in IDLE, if req[0]=1 it is granted regardless of pointer. The pointer still rotates among requesters 1..N_REQ-1 for the remaining grants.
- Not defined: pure round-robin over all N_REQ requesters as above.

Test Plan:
- Reset, then req=4'b0001, cx=cy=100, ROM all free (2'b01) -> grant_id=0, busy high 13 cycles, done=4'b0001 on cycle 14, flags=4'b1111.
- Single requester, ROM wall only at (87,100) -> flags=4'b0111. Second run with wall only at (112,111) -> flags=4'b1110.
- req=4'b1111 held, all free -> grants in order 0,1,2,3,0, done pulses 14 cycles apart, each done one-hot.
- cx=5, cy=5, bench ROM logs addresses -> first probe reads (504,5); probe 4 reads (5,504); no X on rom_x/rom_y.
- reset asserted at probe k=6, then released with req=4'b0010 -> no done during reset; next done=4'b0010 with fresh flags.
- MAP_PROBE_PRIO_EN defined, req=4'b1110 held, req[0] raised during requester 1's sequence -> next grant is 0, then 2, skipping none of 1..3 over time.
